// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-to-ALU sequencer.
//
// Contents:
//   - Default operand and opcode widths.
//   - One-hot state encodings and the matching state enum.
//   - ALU opcode constants.
//   - A helper that tells which states count as "busy".
package alu_uart_pkg;

  localparam int DEF_SIZEDATA = 8;
  localparam int DEF_SIZEOP   = 6;

  localparam logic [5:0] STATE_OPA     = 6'b000001;
  localparam logic [5:0] STATE_OPB     = 6'b000010;
  localparam logic [5:0] STATE_OPCODE  = 6'b000100;
  localparam logic [5:0] STATE_EXEC    = 6'b001000;
  localparam logic [5:0] STATE_SEND    = 6'b010000;
  localparam logic [5:0] STATE_WAIT_TX = 6'b100000;

  typedef enum logic [5:0] {
    ST_OPA     = STATE_OPA,
    ST_OPB     = STATE_OPB,
    ST_OPCODE  = STATE_OPCODE,
    ST_EXEC    = STATE_EXEC,
    ST_SEND    = STATE_SEND,
    ST_WAIT_TX = STATE_WAIT_TX
  } state_e;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

  // A frame is in flight (no new RX bytes accepted) in these states.
  function automatic logic is_busy_state(input state_e s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/intf_timeout_counter.sv
// Inter-byte idle counter for the sequencer.
//
// Counts cycles while enabled and not cleared. The count is held at zero
// whenever the counter is disabled, so entry into a counted state always
// starts from zero. expire is combinational and is suppressed in the cycle
// a clear arrives, letting a byte that lands on the last cycle win.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   clr     in   restart the count (a byte arrived)
//   en      in   counting window active
//   expire  out  count reached CYCLES-1 with no clear this cycle
module intf_timeout_counter #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int             CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// UART-to-ALU sequencer.
//
// Collects operand A, operand B and opcode from three consecutive RX bytes,
// presents them to the ALU, waits ALU_LATENCY extra cycles, captures the
// result and hands it to the UART TX with a start/done handshake. Bytes that
// arrive while a frame is in flight are dropped and reported.
//
// Optional feature (macro INTF_TIMEOUT_EN): abort a partial frame when no
// byte arrives for TIMEOUT_CYCLES cycles in OPB/OPCODE. Without the macro
// o_timeout is tied low and those states wait indefinitely.
//
// Ports:
//   i_clock       in   clock, rising edge
//   i_reset       in   synchronous active-high reset
//   i_rx_done     in   RX byte valid pulse
//   i_rx_data     in   RX byte
//   i_alu_result  in   ALU result
//   i_tx_done     in   TX finished pulse
//   o_alu_datoa   out  operand A
//   o_alu_datob   out  operand B
//   o_alu_opcode  out  opcode
//   o_tx_start    out  TX start pulse
//   o_tx_data     out  captured result for TX
//   o_busy        out  frame in flight
//   o_rx_drop     out  RX byte ignored pulse
//   o_timeout     out  frame aborted pulse
module alu_uart_sequencer
  import alu_uart_pkg::*;
#(
  parameter int SIZEDATA       = DEF_SIZEDATA,
  parameter int SIZEOP         = DEF_SIZEOP,
  parameter int ALU_LATENCY    = 0,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic [SIZEDATA-1:0] i_alu_result,
  input  logic                i_tx_done,
  output logic [SIZEDATA-1:0] o_alu_datoa,
  output logic [SIZEDATA-1:0] o_alu_datob,
  output logic [SIZEOP-1:0]   o_alu_opcode,
  output logic                o_tx_start,
  output logic [SIZEDATA-1:0] o_tx_data,
  output logic                o_busy,
  output logic                o_rx_drop,
  output logic                o_timeout
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LATENCY);

  state_e              state_q, state_d;
  logic [SIZEDATA-1:0] datoa_q, datoa_d;
  logic [SIZEDATA-1:0] datob_q, datob_d;
  logic [SIZEOP-1:0]   opcode_q, opcode_d;
  logic [SIZEDATA-1:0] tx_data_q, tx_data_d;
  logic [3:0]          lat_q, lat_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                rx_drop_q, rx_drop_d;
  logic                timeout_q, timeout_d;
  logic                tmo_expire;

`ifdef INTF_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (state_q == ST_OPB) || (state_q == ST_OPCODE);

  intf_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clock),
    .rst    (i_reset),
    .clr    (i_rx_done),
    .en     (tmo_en),
    .expire (tmo_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expire         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    datoa_d    = datoa_q;
    datob_d    = datob_q;
    opcode_d   = opcode_q;
    tx_data_d  = tx_data_q;
    lat_d      = lat_q;
    tx_start_d = 1'b0;
    rx_drop_d  = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_OPA: begin
        if (i_rx_done) begin
          datoa_d = i_rx_data;
          state_d = ST_OPB;
        end
      end
      ST_OPB: begin
        if (i_rx_done) begin
          datob_d = i_rx_data;
          state_d = ST_OPCODE;
        end else if (tmo_expire) begin
          state_d   = ST_OPA;
          timeout_d = 1'b1;
        end
      end
      ST_OPCODE: begin
        if (i_rx_done) begin
          opcode_d = i_rx_data[SIZEOP-1:0];
          lat_d    = '0;
          state_d  = ST_EXEC;
        end else if (tmo_expire) begin
          state_d   = ST_OPA;
          timeout_d = 1'b1;
        end
      end
      ST_EXEC: begin
        // EXEC spans ALU_LATENCY+1 cycles; the result is sampled on the last.
        if (lat_q == LAT_LAST) begin
          tx_data_d  = i_alu_result;
          tx_start_d = 1'b1;
          state_d    = ST_SEND;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_OPA;
        end
      end
      default: begin
        state_d = ST_OPA;
      end
    endcase

    if (i_rx_done && is_busy_state(state_q)) begin
      rx_drop_d = 1'b1;
    end

    busy_d = is_busy_state(state_d);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_OPA;
      datoa_q    <= '0;
      datob_q    <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      lat_q      <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      datoa_q    <= datoa_d;
      datob_q    <= datob_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      lat_q      <= lat_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      rx_drop_q  <= rx_drop_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_alu_datoa  = datoa_q;
  assign o_alu_datob  = datob_q;
  assign o_alu_opcode = opcode_q;
  assign o_tx_start   = tx_start_q;
  assign o_tx_data    = tx_data_q;
  assign o_busy       = busy_q;
  assign o_rx_drop    = rx_drop_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: two instances (ALU latency 0 and 3) share
// the same RX/TX stimulus; each drives its own ALU model.
module tb_alu_uart_sequencer;
  import alu_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rx_done, tx_done;
  logic [7:0] rx_data;

  logic [7:0] alu_res [2];
  logic [7:0] datoa   [2];
  logic [7:0] datob   [2];
  logic [5:0] opcode  [2];
  logic [7:0] tx_data [2];
  logic       tx_start[2];
  logic       busy    [2];
  logic       rx_drop [2];
  logic       tmo     [2];

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    logic [7:0] r;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      SRA:     r = 8'($signed(a) >>> b);
      SRL:     r = a >> b;
      NOR:     r = ~(a | b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign alu_res[0] = alu_f(datoa[0], datob[0], opcode[0]);
  assign alu_res[1] = alu_f(datoa[1], datob[1], opcode[1]);

  alu_uart_sequencer #(
    .SIZEDATA(8), .SIZEOP(6), .ALU_LATENCY(0), .TIMEOUT_CYCLES(16)
  ) u_lat0 (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_alu_result(alu_res[0]), .i_tx_done(tx_done),
    .o_alu_datoa(datoa[0]), .o_alu_datob(datob[0]), .o_alu_opcode(opcode[0]),
    .o_tx_start(tx_start[0]), .o_tx_data(tx_data[0]), .o_busy(busy[0]),
    .o_rx_drop(rx_drop[0]), .o_timeout(tmo[0])
  );

  alu_uart_sequencer #(
    .SIZEDATA(8), .SIZEOP(6), .ALU_LATENCY(3), .TIMEOUT_CYCLES(16)
  ) u_lat3 (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_alu_result(alu_res[1]), .i_tx_done(tx_done),
    .o_alu_datoa(datoa[1]), .o_alu_datob(datob[1]), .o_alu_opcode(opcode[1]),
    .o_tx_start(tx_start[1]), .o_tx_data(tx_data[1]), .o_busy(busy[1]),
    .o_rx_drop(rx_drop[1]), .o_timeout(tmo[1])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t       vt  [9];
  logic [5:0] ops [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    step();
    rx_done = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("rx_drop_on_accept%0d", k), rx_drop[k], 0);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_datoa%0d", tag, k), datoa[k], 0);
      chk($sformatf("%s_datob%0d", tag, k), datob[k], 0);
      chk($sformatf("%s_opcode%0d", tag, k), opcode[k], 0);
      chk($sformatf("%s_tx_data%0d", tag, k), tx_data[k], 0);
      chk($sformatf("%s_tx_start%0d", tag, k), tx_start[k], 0);
      chk($sformatf("%s_busy%0d", tag, k), busy[k], 0);
      chk($sformatf("%s_rx_drop%0d", tag, k), rx_drop[k], 0);
      chk($sformatf("%s_timeout%0d", tag, k), tmo[k], 0);
    end
  endtask

  // Called right after the opcode byte (sent in cycle n). Expects tx_start
  // exactly at n+2+latency, stable operands, busy throughout, optional drop
  // of an injected byte, then releases both instances with one tx_done.
  task automatic complete(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [7:0] exp, input bit inject);
    int n = cyc - 1;
    int es;
    while (cyc <= n + 8) begin
      for (int k = 0; k < 2; k++) begin
        es = n + 2 + ((k == 0) ? 0 : 3);
        chk($sformatf("tx_start%0d", k), tx_start[k], (cyc == es) ? 1 : 0);
        if (cyc >= es) chk($sformatf("tx_data%0d", k), tx_data[k], exp);
        chk($sformatf("busy%0d", k), busy[k], 1);
        chk($sformatf("datoa%0d", k), datoa[k], a);
        chk($sformatf("datob%0d", k), datob[k], b);
        chk($sformatf("opcode%0d", k), opcode[k], opb[5:0]);
        chk($sformatf("rx_drop%0d", k), rx_drop[k], (inject && cyc == n + 7) ? 1 : 0);
        chk($sformatf("timeout%0d", k), tmo[k], 0);
      end
      if (inject && cyc == n + 6) begin
        rx_done = 1'b1;
        rx_data = 8'hAA;
      end
      step();
      rx_done = 1'b0;
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy_after_done%0d", k), busy[k], 0);
      chk($sformatf("tx_data_hold%0d", k), tx_data[k], exp);
    end
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] exp, input int gap, input bit inject);
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte(op);
    complete(a, b, op, exp, inject);
  endtask

  initial begin
    vt[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vt[1] = '{8'h05, 8'h03, 8'h22, 8'h02};
    vt[2] = '{8'h0F, 8'hF0, 8'h25, 8'hFF};
    vt[3] = '{8'hF0, 8'h0F, 8'h24, 8'h00};
    vt[4] = '{8'hAA, 8'hFF, 8'h26, 8'h55};
    vt[5] = '{8'h80, 8'h01, 8'h03, 8'hC0};
    vt[6] = '{8'h80, 8'h01, 8'h02, 8'h40};
    vt[7] = '{8'h00, 8'h00, 8'h27, 8'hFF};
    vt[8] = '{8'h12, 8'h34, 8'hE0, 8'h46};
    ops = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR};

    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    idle(2);
    chk_zero("reset");
    rst = 1'b0;

    // A stray tx_done out of WAIT_TX must be ignored.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("stray_done_busy%0d", k), busy[k], 0);

    for (int i = 0; i < 9; i++) frame(vt[i].a, vt[i].b, vt[i].op, vt[i].res, i % 3, 1'b0);

    // Drop while busy, then a back-to-back frame right after tx_done.
    frame(8'h05, 8'h03, 8'h20, 8'h08, 0, 1'b1);
    frame(8'h0F, 8'hF0, 8'h25, 8'hFF, 0, 1'b0);

    // Reset mid-frame.
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("rst_midframe");
    frame(8'h33, 8'h44, 8'h20, 8'h77, 0, 1'b0);

    // Reset mid-TX; the tx_done that follows must not disturb OPA.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("rst_midtx");
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("post_rst_done_busy%0d", k), busy[k], 0);
      chk($sformatf("post_rst_done_start%0d", k), tx_start[k], 0);
    end
    frame(8'h09, 8'h04, 8'h22, 8'h05, 1, 1'b0);

`ifdef INTF_TIMEOUT_EN
    send_byte(8'h44);
    repeat (15) begin
      for (int k = 0; k < 2; k++) chk($sformatf("tmo_early%0d", k), tmo[k], 0);
      step();
    end
    for (int k = 0; k < 2; k++) chk($sformatf("tmo_early%0d", k), tmo[k], 0);
    step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tmo_pulse%0d", k), tmo[k], 1);
      chk($sformatf("tmo_datoa%0d", k), datoa[k], 8'h44);
      chk($sformatf("tmo_busy%0d", k), busy[k], 0);
    end
    step();
    for (int k = 0; k < 2; k++) chk($sformatf("tmo_one_cycle%0d", k), tmo[k], 0);
    frame(8'h66, 8'h77, 8'h20, 8'hDD, 0, 1'b0);

    // Byte arriving on the expiry cycle wins.
    send_byte(8'h44);
    idle(15);
    send_byte(8'h55);
    for (int k = 0; k < 2; k++) chk($sformatf("tmo_coincide%0d", k), tmo[k], 0);
    send_byte(8'h20);
    complete(8'h44, 8'h55, 8'h20, 8'h99, 1'b0);
`else
    send_byte(8'h44);
    repeat (20) begin
      for (int k = 0; k < 2; k++) chk($sformatf("no_tmo%0d", k), tmo[k], 0);
      step();
    end
    send_byte(8'h55);
    send_byte(8'h20);
    complete(8'h44, 8'h55, 8'h20, 8'h99, 1'b0);
`endif

    // Randomized frames against the ALU reference.
    for (int i = 0; i < 25; i++) begin
      logic [7:0] a, b, op;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = {2'($urandom), ops[$urandom_range(0, 7)]};
      frame(a, b, op, alu_f(a, b, op[5:0]), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Parametrised successor to the UART-to-ALU interface. It collects operand A, operand B and the opcode as three consecutive UART RX bytes, holds them stable on the ALU inputs, and waits a configurable ALU latency. It then captures the result and hands it to the UART TX through a start/done handshake. It sits between uart_rx/uart_tx and the ALU, adds inter-byte timeout recovery and RX-drop reporting, and blocks new frames until transmission completes.

Parameters:
SIZEDATA, 8, width of RX bytes, operands, result and TX data
SIZEOP, 6, opcode width; taken from i_rx_data[SIZEOP-1:0]
ALU_LATENCY, 0, extra clock cycles the ALU needs after operands and opcode are stable (0..15)
TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between bytes of one frame before abort (used only with the timeout feature)

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
i_rx_data  in  SIZEDATA  received byte
i_alu_result  in  SIZEDATA  ALU result
i_tx_done  in  1  one-cycle pulse, TX finished the byte
o_alu_datoa  out  SIZEDATA  registered operand A
o_alu_datob  out  SIZEDATA  registered operand B
o_alu_opcode  out  SIZEOP  registered opcode
o_tx_start  out  1  one-cycle pulse, start TX of o_tx_data
o_tx_data  out  SIZEDATA  registered result for TX
o_busy  out  1  high in EXEC, SEND and WAIT_TX
o_rx_drop  out  1  one-cycle pulse, an RX byte was ignored
o_timeout  out  1  one-cycle pulse, frame aborted by timeout

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs go to 0 and the state goes to OPA. Reset wins over every other event, including mid-frame and mid-TX. A pending i_tx_done after reset is ignored.
- States are one-hot: OPA, OPB, OPCODE, EXEC, SEND, WAIT_TX.
- OPA: on i_rx_done, o_alu_datoa <= i_rx_data; go to OPB.
- OPB: on i_rx_done, o_alu_datob <= i_rx_data; go to OPCODE.
- OPCODE: on i_rx_done, o_alu_opcode <= i_rx_data[SIZEOP-1:0]; go to EXEC.
- EXEC:
  - lasts ALU_LATENCY+1 cycles, counted by a latency counter cleared on entry.
  - On its last cycle: o_tx_data <= i_alu_result, o_tx_start <= 1; go to SEND.
- SEND: o_tx_start is high for exactly this one cycle. Go to WAIT_TX; o_tx_start returns to 0.
- WAIT_TX: wait for i_tx_done, then go to OPA. An i_tx_done in any other state is ignored.
- Latency: if the opcode byte's i_rx_done is at cycle N, o_tx_start is high at cycle N+2+ALU_LATENCY.
- Hold rule: operand, opcode and tx_data registers change only at the events above. Otherwise they hold, including across frames.
- i_rx_done in EXEC, SEND or WAIT_TX: the byte is discarded, o_rx_drop pulses the next cycle, and state is unchanged.
- o_busy is a registered decode of the next state, so it is high from cycle N+1 through the cycle WAIT_TX exits.
- Operands are treated as unsigned bit patterns; no sign extension.

Optional Feature:
INTF_TIMEOUT_EN
- Defined:
  - An idle counter runs in OPB and OPCODE. It clears on entry to those states and on each i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1 without i_rx_done, state goes to OPA and o_timeout pulses for one cycle.
  - Partially received registers keep their values.
  - If i_rx_done and expiry coincide, i_rx_done wins and there is no timeout.
  - The counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter exists, o_timeout is tied to 0, and OPB/OPCODE wait indefinitely.

Decomposition:
- Shared package alu_uart_pkg holds:
  - the one-hot state localparams (STATE_OPA..STATE_WAIT_TX, 6 bits);
  - the opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111;
  - the default SIZEDATA and SIZEOP.
- One sub-module is natural: intf_timeout_counter (clear, enable, expire pulse), instantiated only under INTF_TIMEOUT_EN.

Test Plan:
- Basic ADD, ALU_LATENCY=0: RX 0x05, 0x03, 0x20; ALU model returns 0x08 → o_alu_datoa=0x05, o_alu_datob=0x03, o_alu_opcode=0x20. o_tx_start pulses once at N+2 with o_tx_data=0x08. i_tx_done returns the block to OPA and o_busy falls.
- ALU_LATENCY=3: same frame with SUB 0x22 and ALU result 0x02 → o_tx_start at N+5, o_tx_data=0x02, and o_alu_* stable throughout EXEC.
- RX during busy: extra byte 0xAA while in WAIT_TX → o_rx_drop pulses once, o_tx_data is unchanged, and the next frame 0x0F, 0xF0, 0x25 (OR) gives 0xFF.
- Reset mid-frame: after bytes 0x11, 0x22, assert i_reset for 1 cycle → all outputs 0 and state OPA. The next three bytes form a fresh frame.
- Timeout (INTF_TIMEOUT_EN, TIMEOUT_CYCLES=16): byte 0x44, then idle for 16 cycles → o_timeout pulses, state is OPA, o_alu_datoa stays 0x44. Also check that i_rx_done coinciding with expiry does not time out.
- Back-to-back: i_tx_done and the next frame's first i_rx_done in consecutive cycles → no drop, and the second frame is processed correctly.
